crc10_frame_ctrl: RTL and testbench

//  Framing stage directly upstream of the CRC10 checker. It takes descrambled 62-bit

---
 rtl/crc10_frame_pkg.sv | 26 ++
 rtl/crc10_slip_fifo.sv | 72 +++++++
 rtl/crc10_frame_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_crc10_frame_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/crc10_frame_pkg.sv
`default_nettype none
// ============================================================================
//  crc10_frame_pkg
//  Shared types for the CRC10 framing stage: FSM states and slip-FIFO entry.
//  Revision: 1.0
// ============================================================================
package crc10_frame_pkg;

    localparam int WORD_W = 62;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DROP  = 2'd2
    } frame_state_t;

    // abort_after marks a first word that cut the previous frame short
    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              first;
        logic              tail;
        logic              abort_after;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/crc10_slip_fifo.sv
`default_nettype none
// ============================================================================
//  crc10_slip_fifo
//  Small synchronous FIFO that absorbs the idle-cycle slip; push+pop allowed
//  in the same cycle, including when full.
//  Revision: 1.0
// ============================================================================
module crc10_slip_fifo
    import crc10_frame_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                         clk_390p625M,
    input  logic                         rst_n,
    input  logic                         push,
    input  fifo_entry_t                  push_entry,
    input  logic                         pop,
    output fifo_entry_t                  head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    fifo_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (r_level == LVL_W'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk_390p625M) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk_390p625M) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/crc10_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  crc10_frame_ctrl
//  Frames descrambled words for the CRC10 checker: idle cycle after each frame
//  end, slip absorption, abort/drop handling. Statistics counters are built
//  only when CRC10_FRAME_STATS_EN is defined; otherwise they read 0.
//  Revision: 1.0
// ============================================================================
module crc10_frame_ctrl
    import crc10_frame_pkg::*;
#(
    parameter int FRAME_WORDS = 16,
    parameter int SLIP_MAX    = 2,
    parameter int CNT_W       = 22
) (
    input  logic              clk_390p625M,
    input  logic              rst_n,
    input  logic              desc_valid,
    input  logic [WORD_W-1:0] desc_data,
    input  logic              desc_sof,
    output logic              crc10_en,
    output logic [WORD_W-1:0] crc10_data_in,
    output logic              frame_tail_flag,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  abort_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int DEPTH  = SLIP_MAX + 1;
    localparam int WCNT_W = $clog2(FRAME_WORDS + 1);
    localparam int SLIP_W = (SLIP_MAX > 0) ? $clog2(SLIP_MAX + 1) : 1;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    frame_state_t       r_state;
    frame_state_t       w_state_next;
    logic [WCNT_W-1:0]  r_wcnt;
    logic [WCNT_W-1:0]  w_wcnt_next;
    logic [WCNT_W-1:0]  w_wcnt_inc;
    logic [SLIP_W-1:0]  r_slip;
    logic [SLIP_W-1:0]  w_slip_next;
    logic [SLIP_W:0]    w_slip_sum;
    logic               w_slip_full;
    logic               r_prev_en;
    logic               w_push;
    fifo_entry_t        w_entry;
    logic               w_abort;
    logic               w_drop;
    fifo_entry_t        w_head;
    logic               w_full;
    logic               w_empty;
    logic [LVL_W-1:0]   w_level;
    logic               w_bubble;
    logic               w_emit;
    logic               w_unused;

    crc10_slip_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_390p625M (clk_390p625M),
        .rst_n        (rst_n),
        .push         (w_push),
        .push_entry   (w_entry),
        .pop          (w_emit),
        .head         (w_head),
        .full         (w_full),
        .empty        (w_empty),
        .level        (w_level)
    );

    // A new frame's first word directly behind an emitted word must wait one cycle
    assign w_bubble        = !w_empty && w_head.first && r_prev_en;
    assign w_emit          = !w_empty && !w_bubble;
    assign crc10_en        = w_emit;
    assign crc10_data_in   = w_emit ? w_head.data : '0;
    assign frame_tail_flag = w_emit && w_head.tail;

    // Slip this edge will leave behind; a new frame at that slip has no room for its bubble
    assign w_slip_sum  = {1'b0, r_slip} + {{SLIP_W{1'b0}}, w_bubble};
    assign w_slip_full = (w_slip_sum >= (SLIP_W+1)'(SLIP_MAX));
    assign w_wcnt_inc  = r_wcnt + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_wcnt_next  = r_wcnt;
        w_push       = 1'b0;
        w_entry      = '{data: desc_data, first: 1'b0, tail: 1'b0, abort_after: 1'b0};
        w_abort      = 1'b0;
        w_drop       = 1'b0;
        if (desc_valid && desc_sof) begin
            w_abort     = (r_state == FRAME);
            w_wcnt_next = WCNT_W'(1);
            if (w_slip_full) begin
                w_drop       = 1'b1;
                w_state_next = DROP;
            end else begin
                w_push              = 1'b1;
                w_entry.first       = 1'b1;
                w_entry.abort_after = (r_state == FRAME);
                w_state_next        = FRAME;
            end
        end else if (desc_valid) begin
            case (r_state)
                FRAME: begin
                    w_push      = 1'b1;
                    w_wcnt_next = w_wcnt_inc;
                    if (w_wcnt_inc == WCNT_W'(FRAME_WORDS)) begin
                        w_entry.tail = 1'b1;
                        w_state_next = IDLE;
                    end
                end
                DROP: begin
                    w_wcnt_next = w_wcnt_inc;
                    if (w_wcnt_inc == WCNT_W'(FRAME_WORDS)) begin
                        w_state_next = IDLE;
                    end
                end
                default: ;
            endcase
        end else begin
            w_abort      = (r_state == FRAME);
            w_state_next = IDLE;
        end
    end

    always_comb begin
        w_slip_next = r_slip;
        if (w_bubble && (r_slip != SLIP_W'(SLIP_MAX))) begin
            w_slip_next = r_slip + 1'b1;
        end else if (w_emit && !w_push && (r_slip != '0)) begin
            w_slip_next = r_slip - 1'b1;
        end
    end

    always_ff @(posedge clk_390p625M) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wcnt    <= '0;
            r_slip    <= '0;
            r_prev_en <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_wcnt    <= w_wcnt_next;
            r_slip    <= w_slip_next;
            r_prev_en <= w_emit;
        end
    end

`ifdef CRC10_FRAME_STATS_EN
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_abort_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge clk_390p625M) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_abort_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_emit && w_head.tail && !(&r_frame_cnt)) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_abort && !(&r_abort_cnt)) begin
                r_abort_cnt <= r_abort_cnt + 1'b1;
            end
            if (w_drop && !(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign abort_cnt = r_abort_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign w_unused  = ^{w_level, w_full, w_head.abort_after};
`else
    assign frame_cnt = '0;
    assign abort_cnt = '0;
    assign drop_cnt  = '0;
    assign w_unused  = ^{w_level, w_full, w_head.abort_after, w_abort, w_drop};
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc10_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  tb_crc10_frame_ctrl
//  Scoreboard bench: stimulus queues expected words, a monitor checks output.
//  Revision: 1.0
// ============================================================================
module tb_crc10_frame_ctrl;

    localparam int FW = 16;
    localparam int SM = 1;
    localparam int CW = 22;

    logic          clk_390p625M = 1'b0;
    logic          rst_n        = 1'b0;
    logic          desc_valid   = 1'b0;
    logic [61:0]   desc_data    = '0;
    logic          desc_sof     = 1'b0;
    logic          crc10_en;
    logic [61:0]   crc10_data_in;
    logic          frame_tail_flag;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] abort_cnt;
    logic [CW-1:0] drop_cnt;

    crc10_frame_ctrl #(
        .FRAME_WORDS (FW),
        .SLIP_MAX    (SM),
        .CNT_W       (CW)
    ) dut (
        .clk_390p625M    (clk_390p625M),
        .rst_n           (rst_n),
        .desc_valid      (desc_valid),
        .desc_data       (desc_data),
        .desc_sof        (desc_sof),
        .crc10_en        (crc10_en),
        .crc10_data_in   (crc10_data_in),
        .frame_tail_flag (frame_tail_flag),
        .frame_cnt       (frame_cnt),
        .abort_cnt       (abort_cnt),
        .drop_cnt        (drop_cnt)
    );

    initial forever #2 clk_390p625M = ~clk_390p625M;

    typedef struct {
        logic [61:0] data;
        logic        tail;
        int          gap;   // required idle cycles before this word, -1 = any
    } exp_t;

    exp_t exp_q[$];
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   exp_frames = 0;
    int   exp_aborts = 0;
    int   exp_drops  = 0;
    logic mon_en     = 1'b0;
    int   idle_run   = 100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [CW-1:0] sat(input int v);
        return (v >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(v);
    endfunction

    always @(negedge clk_390p625M) begin
        exp_t e;
        if (mon_en) begin
            if (crc10_en) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got data 0x%0h, expected no word", crc10_data_in);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", {2'b0, crc10_data_in}, {2'b0, e.data});
                    check("word_tail", {63'b0, frame_tail_flag}, {63'b0, e.tail});
                    if (e.gap >= 0) begin
                        check("gap_before", 64'(idle_run), 64'(e.gap));
                    end
                end
                idle_run = 0;
            end else begin
                check("idle_outputs", {1'b0, frame_tail_flag, crc10_data_in}, 64'd0);
                idle_run++;
            end
        end
    end

    task automatic drive(input logic v, input logic s, input logic [61:0] d);
        desc_valid = v;
        desc_sof   = s;
        desc_data  = d;
        @(posedge clk_390p625M);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
    endtask

    // nwords < FW gives a truncated frame; emit=0 for a frame the DUT must drop
    task automatic send_frame(input logic [61:0] base, input int nwords, input bit emit,
                              input int gap_first);
        exp_t e;
        for (int i = 0; i < nwords; i++) begin
            if (emit) begin
                e.data = base + 62'(i + 1);
                e.tail = (i == FW - 1);
                e.gap  = (i == 0) ? gap_first : 0;
                exp_q.push_back(e);
            end
            drive(1'b1, i == 0, base + 62'(i + 1));
        end
    endtask

    task automatic check_cnts(input string tag);
`ifdef CRC10_FRAME_STATS_EN
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(sat(exp_frames)));
        check({tag, "_abort_cnt"}, 64'(abort_cnt), 64'(sat(exp_aborts)));
        check({tag, "_drop_cnt"},  64'(drop_cnt),  64'(sat(exp_drops)));
`else
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
        check({tag, "_abort_cnt"}, 64'(abort_cnt), 64'd0);
        check({tag, "_drop_cnt"},  64'(drop_cnt),  64'd0);
`endif
    endtask

    initial begin
        // reset and idle
        rst_n = 1'b0;
        repeat (2) @(posedge clk_390p625M);
        #1;
        check("reset_en",   64'(crc10_en), 64'd0);
        check("reset_data", 64'(crc10_data_in), 64'd0);
        check("reset_tail", 64'(frame_tail_flag), 64'd0);
        check_cnts("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(3);

        // single frame, first word visible one cycle after acceptance
        begin
            exp_t e;
            e.data = 62'h1; e.tail = 1'b0; e.gap = -1;
            exp_q.push_back(e);
            drive(1'b1, 1'b1, 62'h1);
            check("latency_en",   64'(crc10_en), 64'd1);
            check("latency_data", 64'(crc10_data_in), 64'h1);
            for (int i = 1; i < FW; i++) begin
                e.data = 62'(i + 1); e.tail = (i == FW - 1); e.gap = 0;
                exp_q.push_back(e);
                drive(1'b1, 1'b0, 62'(i + 1));
            end
        end
        idle(4);
        exp_frames = 1;
        check_cnts("one_frame");

        // back-to-back frames: one bubble; after one idle input cycle slip is back to 0
        send_frame(62'h100, FW, 1'b1, -1);
        send_frame(62'h200, FW, 1'b1, 1);
        idle(1);
        send_frame(62'h300, FW, 1'b1, 1);
        idle(4);
        exp_frames += 3;
        check_cnts("back_to_back");

        // three back-to-back frames with SLIP_MAX=1: third one dropped
        send_frame(62'h400, FW, 1'b1, -1);
        send_frame(62'h500, FW, 1'b1, 1);
        send_frame(62'h600, FW, 1'b0, -1);
        idle(4);
        exp_frames += 2;
        exp_drops  += 1;
        check_cnts("drop");

        // abort on gap at word 7
        send_frame(62'h700, 7, 1'b1, -1);
        idle(3);
        exp_aborts += 1;
        check_cnts("abort_gap");

        // abort on early SOF at word 9; new frame follows after one bubble
        send_frame(62'h800, 9, 1'b1, -1);
        send_frame(62'h900, FW, 1'b1, 1);
        idle(4);
        exp_aborts += 1;
        exp_frames += 1;
        check_cnts("abort_sof");

`ifdef CRC10_FRAME_STATS_EN
        force dut.r_abort_cnt = 22'h3FFFFE;
        @(posedge clk_390p625M);
        #1;
        release dut.r_abort_cnt;
        exp_aborts = (1 << CW) - 2;
        for (int k = 0; k < 3; k++) begin
            send_frame(62'hA00 + 62'(k * 16), 2, 1'b1, -1);
            idle(2);
            exp_aborts += 1;
        end
        check("abort_sat", 64'(abort_cnt), 64'h3FFFFF);
`endif

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk_390p625M);
        check("drain_left", 64'(exp_q.size()), 64'd0);
        check_cnts("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
